// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper and the expression block it exercises.
// The master side launches sweeps and supplies y; the slave side is the sweeper.
interface truth_table_sweeper_if;
    logic        start;
    logic        y_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;

    modport master (
        output start, y_in,
        input  a, b, c, d, busy, done, pass, table_out, mismatch_cnt
    );

    modport slave (
        input  start, y_in,
        output a, b, c, d, busy, done, pass, table_out, mismatch_cnt
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks {a,b,c,d} through all 16 vectors, samples y after a settle interval and grades the table.
// Define TTS_Y_SYNC_EN to pass y_in through a 2-flop synchronizer (settle interval grows by 2).
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h0703
) (
    input logic                   clk,
    input logic                   rst_n,
    truth_table_sweeper_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  idx;
    logic [8:0]  settle_cnt;
    logic [15:0] table_q;
    logic [4:0]  mismatch_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic        y_eff;
    logic        accept;
    logic        settle_last;
    logic        last_vec;

`ifdef TTS_Y_SYNC_EN
    localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES + 2);

    logic y_meta;
    logic y_sync;

    // y may come back from a pin or LED loop, so retime it before it is graded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_meta <= 1'b0;
            y_sync <= 1'b0;
        end else begin
            y_meta <= bus.y_in;
            y_sync <= y_meta;
        end
    end

    assign y_eff = y_sync;
`else
    localparam logic [8:0] SETTLE_LOAD = 9'(SETTLE_CYCLES);

    assign y_eff = bus.y_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start in DONE only counts once the result has been published, so busy and start agree
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        settle_last = (settle_cnt == 9'd1);
        last_vec    = (idx == 4'd15);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_last) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                next_state = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                if (bus.start && done_q) begin
                    accept     = 1'b1;
                    next_state = SETTLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The first DONE cycle registers pass from the completed table before done is raised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 4'd0;
            settle_cnt <= 9'd0;
            table_q    <= 16'd0;
            mismatch_q <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else if (accept) begin
            idx        <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
            table_q    <= 16'd0;
            mismatch_q <= 5'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                SETTLE: begin
                    settle_cnt <= settle_cnt - 9'd1;
                end
                SAMPLE: begin
                    table_q[idx] <= y_eff;
                    if (y_eff != EXPECTED[idx]) begin
                        mismatch_q <= mismatch_q + 5'd1;
                    end
                    if (!last_vec) begin
                        idx        <= idx + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        pass_q <= (table_q == EXPECTED);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a            = idx[3];
    assign bus.b            = idx[2];
    assign bus.c            = idx[1];
    assign bus.d            = idx[0];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.table_out    = table_q;
    assign bus.mismatch_cnt = mismatch_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: a timeline model graded every cycle plus
// literal end-of-sweep expectations; honours TTS_Y_SYNC_EN for the longer settle interval.
module tb_truth_table_sweeper;
    localparam int          SET = 2;
    localparam logic [15:0] EXP = 16'h0703;
`ifdef TTS_Y_SYNC_EN
    localparam int VEC = SET + 3;
`else
    localparam int VEC = SET + 1;
`endif
    localparam int LAT = 16 * VEC + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad   = 0;
    int          y_mode = 0;
    int          model_n = -1;
    logic [15:0] model_table = 16'h0000;

    truth_table_sweeper_if tif ();

    truth_table_sweeper #(
        .SETTLE_CYCLES (SET),
        .EXPECTED      (EXP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif.slave)
    );

    always #5 clk = ~clk;

    // mode 0: the lab expression, mode 1: y stuck at 0, mode 2: y stuck at 1
    function automatic logic expr_y(int mode, int v);
        int a, b, c, d;
        a = (v >> 3) & 1;
        b = (v >> 2) & 1;
        c = (v >> 1) & 1;
        d = v & 1;
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return !((a != 0 && b != 0) || (c != 0 && d != 0) || (a == 0 && (c != 0 || b != 0)));
        endcase
    endfunction

    function automatic logic [15:0] model_full(int mode);
        logic [15:0] t;
        t = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            t[i] = expr_y(mode, i);
        end
        return t;
    endfunction

    always_comb tif.y_in = expr_y(y_mode, int'({tif.a, tif.b, tif.c, tif.d}));

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // model_n counts edges since the accepted start; -1 means idle since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_n <= -1;
        end else if (tif.start && (model_n < 0 || model_n >= LAT)) begin
            model_n <= 0;
        end else if (model_n >= 0 && model_n < LAT) begin
            model_n <= model_n + 1;
        end
    end

    always @(negedge clk) begin : compare
        int          sampled;
        int          idx_e;
        logic [15:0] mask;
        logic [15:0] tab_e;
        int          mm_e;
        logic        busy_e;
        logic        done_e;
        logic        pass_e;
        if (model_n < 0) begin
            idx_e  = 0;
            tab_e  = 16'h0000;
            mm_e   = 0;
            busy_e = 1'b0;
            done_e = 1'b0;
            pass_e = 1'b0;
        end else begin
            sampled = (model_n >= LAT) ? 16 : model_n / VEC;
            idx_e   = (sampled > 15) ? 15 : sampled;
            mask    = 16'((32'd1 << sampled) - 32'd1);
            tab_e   = model_table & mask;
            mm_e    = $countones((model_table ^ EXP) & mask);
            busy_e  = (model_n < LAT);
            done_e  = (model_n >= LAT);
            pass_e  = done_e && (model_table == EXP);
        end
        check_output("vector", 32'({tif.a, tif.b, tif.c, tif.d}), 32'(idx_e));
        check_output("busy", 32'(tif.busy), 32'(busy_e));
        check_output("done", 32'(tif.done), 32'(done_e));
        check_output("pass", 32'(tif.pass), 32'(pass_e));
        check_output("table_out", 32'(tif.table_out), 32'(tab_e));
        check_output("mismatch_cnt", 32'(tif.mismatch_cnt), 32'(mm_e));
    end

    task automatic apply_stimulus(input int mode);
        @(negedge clk);
        #1;
        y_mode      = mode;
        model_table = model_full(mode);
        tif.start   = 1'b1;
        @(negedge clk);
        #1;
        tif.start   = 1'b0;
    endtask

    // Counts edges after the start edge until done, giving up after a fixed budget
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (tif.done !== 1'b1 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] tab, input logic ps, input int mm);
        check_output({tag, " table"}, 32'(tif.table_out), 32'(tab));
        check_output({tag, " pass"}, 32'(tif.pass), 32'(ps));
        check_output({tag, " mismatches"}, 32'(tif.mismatch_cnt), 32'(mm));
    endtask

    initial begin
        int cycles;
        tif.start = 1'b0;

        check_output("model expr table", 32'(model_full(0)), 32'h0703);
        check_output("model stuck0 count", 32'($countones(model_full(1) ^ EXP)), 32'd5);
        check_output("model stuck1 count", 32'($countones(model_full(2) ^ EXP)), 32'd11);

        repeat (3) @(negedge clk);
        check_output("reset vector", 32'({tif.a, tif.b, tif.c, tif.d}), 32'd0);
        check_output("reset busy/done/pass", 32'({tif.busy, tif.done, tif.pass}), 32'd0);
        check_output("reset table", 32'(tif.table_out), 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        apply_stimulus(0);
        wait_done(cycles);
        check_output("expr latency", 32'(cycles), 32'(LAT));
        check_result("expr", 16'h0703, 1'b1, 0);
        repeat (3) @(negedge clk);
        check_result("expr hold", 16'h0703, 1'b1, 0);

        apply_stimulus(1);
        wait_done(cycles);
        check_output("stuck0 latency", 32'(cycles), 32'(LAT));
        check_result("stuck0", 16'h0000, 1'b0, 5);

        apply_stimulus(2);
        wait_done(cycles);
        check_result("stuck1", 16'hFFFF, 1'b0, 11);

        apply_stimulus(0);
        repeat (9) @(negedge clk);
        #1 tif.start = 1'b1;
        @(negedge clk);
        #1 tif.start = 1'b0;
        wait_done(cycles);
        check_output("restart ignored latency", 32'(cycles + 10), 32'(LAT));
        check_result("restart ignored", 16'h0703, 1'b1, 0);

        apply_stimulus(1);
        repeat (7 * VEC) @(negedge clk);
        check_output("mid-sweep vector", 32'({tif.a, tif.b, tif.c, tif.d}), 32'd7);
        #1 rst_n = 1'b0;
        #1;
        check_output("async reset vector", 32'({tif.a, tif.b, tif.c, tif.d}), 32'd0);
        check_output("async reset busy", 32'(tif.busy), 32'd0);
        check_output("async reset mismatches", 32'(tif.mismatch_cnt), 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        apply_stimulus(0);
        wait_done(cycles);
        check_output("post-reset latency", 32'(cycles), 32'(LAT));
        check_result("post-reset", 16'h0703, 1'b1, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Stimulus-and-capture stage placed directly upstream of a 4-input combinational Boolean-expression block.
- Drives the block's a, b, c, d inputs through all 16 combinations in binary order, waits a settle interval, then samples the block's y output.
- Assembles the captured 16-entry truth table, compares it against an expected table and reports pass/fail plus a mismatch count.
- Used for board bring-up and lab self-check of the expression blocks.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before y is sampled; legal range 1..255.
- EXPECTED, 16'h0703, expected truth table; bit i is the expected y for vector i = {a,b,c,d}.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sweep
- y_in  input  1  y output of the downstream expression block
- a  output  1  stimulus bit 3 (MSB of vector index)
- b  output  1  stimulus bit 2
- c  output  1  stimulus bit 1
- d  output  1  stimulus bit 0 (LSB)
- busy  output  1  high while a sweep is in progress
- done  output  1  high from sweep completion until the next accepted start
- pass  output  1  valid while done=1; 1 when table_out == EXPECTED
- table_out  output  16  captured truth table; bit i = y_in sampled for vector i
- mismatch_cnt  output  5  number of vectors where y_in != EXPECTED[i], range 0..16

Behaviour:
- Interface: one clock (clk), rising edge. Reset rst_n is asynchronous, active-low.
- Reset values (asynchronous, immediate on rst_n low):
  - a, b, c, d = 0; busy = 0; done = 0; pass = 0; table_out = 0; mismatch_cnt = 0.
  - FSM goes to IDLE; vector index idx = 0; settle counter = 0.
  - Reset mid-sweep aborts the sweep; no partial result is retained.
- {a,b,c,d} are registered and always equal idx[3:0].
- FSM states:
  - IDLE: busy=0, done=0. On start=1: clear table_out and mismatch_cnt, set idx=0, load settle counter, go to SETTLE.
  - SETTLE: busy=1. Count SETTLE_CYCLES clock cycles with the vector held. On the last count, go to SAMPLE.
  - SAMPLE (1 cycle): busy=1.
    - Write y_in into table_out[idx].
    - Increment mismatch_cnt if y_in != EXPECTED[idx].
    - If idx == 15, go to DONE; otherwise idx <= idx+1, reload settle counter, go to SETTLE.
  - DONE: busy=0, done=1, pass=(table_out == EXPECTED), registered on entry. Vector holds at 4'b1111. On start=1, behave exactly as start in IDLE.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises 16*(SETTLE_CYCLES+1)+1 cycles after the cycle in which start is sampled.
- start while busy=1 is ignored (no restart, no effect on counters).
- idx is 4 bits and never wraps inside a sweep; the exit at idx == 15 is explicit.
- mismatch_cnt is 5 bits so that 16 mismatches is representable; it never saturates or wraps.
- table_out and mismatch_cnt update live during the sweep. They are final and stable while done=1.
- y_in is sampled only in SAMPLE; its value in any other state is don't-care.

Optional Feature:
- Macro: TTS_Y_SYNC_EN.
- With the macro defined:
  - y_in passes through a 2-flop synchronizer (both flops reset to 0 by rst_n) before use.
  - The effective settle interval becomes SETTLE_CYCLES+2, so each vector occupies SETTLE_CYCLES+3 cycles.
  - Total latency becomes 16*(SETTLE_CYCLES+3)+1 cycles.
  - Use this when y_in returns from an external pin or LED loop.
- Without the macro: y_in is used directly, with the timing stated above.

Test Plan:
- Bench models y_in = ~((a&b)|(c&d)|(~a&(c|b))), SETTLE_CYCLES=2, pulse start -> done rises 49 cycles later; table_out=16'h0703, pass=1, mismatch_cnt=0.
- Bench drives y_in stuck at 0 -> table_out=16'h0000, pass=0, mismatch_cnt=5.
- Bench drives y_in stuck at 1 -> table_out=16'hFFFF, pass=0, mismatch_cnt=11.
- Pulse start again 10 cycles into a sweep -> ignored; done still rises at cycle 49 from the first start with the correct result.
- Assert rst_n low during vector idx=7, release, then start -> all outputs 0 during reset; the new sweep starts from idx=0 and completes normally.
- With TTS_Y_SYNC_EN defined and the same model as the first scenario -> done rises at cycle 81; table_out=16'h0703, pass=1.
